// File: rtl/sonata_pinmux_pkg.sv
// Shared register-map constants and address/select typedefs for the pin mux.
package sonata_pinmux_pkg;

    localparam logic [11:0] OUT_SEL_BASE = 12'h000;
    localparam logic [11:0] IN_SEL_BASE  = 12'h400;
    localparam logic [11:0] FILT_EN_BASE = 12'h800;
    localparam logic [11:0] CTRL_ADDR    = 12'hC00;

    localparam int CTRL_LOCK_BIT = 0;

    // The top two address bits select one of the four register banks.
    typedef enum logic [1:0] {
        REGION_OUT_SEL = 2'd0,
        REGION_IN_SEL  = 2'd1,
        REGION_FILT_EN = 2'd2,
        REGION_CTRL    = 2'd3
    } region_e;

    typedef logic [7:0] reg_idx_t;

    // Byte address split into bank, word index within the bank, byte offset.
    typedef struct packed {
        region_e     region;
        reg_idx_t    idx;
        logic [1:0]  byte_off;
    } reg_addr_s;

endpackage

// File: rtl/sonata_pin_filter.sv
// Per-pin input conditioning: 2-flop synchroniser followed by a stability filter.
module sonata_pin_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic             filt;
    logic [CNT_W-1:0] cnt;

    // Synchroniser; resets high so idle-high lines do not glitch out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= d_i;
            sync <= meta;
        end
    end

    // Filtered value only moves after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (!en_i) begin
            filt <= sync;
            cnt  <= '0;
        end else if (sync == filt) begin
            cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
            filt <= sync;
            cnt  <= '0;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

    assign q_o = filt;

endmodule

// File: rtl/sonata_pinmux_prog.sv
// Run-time programmable pin multiplexer with register-selected routing and lock.
module sonata_pinmux_prog
    import sonata_pinmux_pkg::*;
#(
    parameter int                    PIN_NUM        = 70,
    parameter int                    BLK_OUT_NUM    = 48,
    parameter int                    BLK_IN_NUM     = 24,
    parameter int                    FILTER_CYCLES  = 4,
    parameter logic [BLK_IN_NUM-1:0] BLK_IN_DEFAULT = '1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_req_i,
    input  logic                   reg_we_i,
    input  logic [11:0]            reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_rvalid_o,
    output logic                   reg_err_o,
    input  logic [BLK_OUT_NUM-1:0] blk_out_i,
    input  logic [BLK_OUT_NUM-1:0] blk_oe_i,
    output logic [BLK_IN_NUM-1:0]  blk_in_o,
    input  logic [PIN_NUM-1:0]     pin_in_i,
    output logic [PIN_NUM-1:0]     pin_out_o,
    output logic [PIN_NUM-1:0]     pin_oe_o
);

    localparam int OSEL_W    = $clog2(BLK_OUT_NUM + 1);
    localparam int ISEL_W    = $clog2(PIN_NUM + 1);
    localparam int FW        = (PIN_NUM + 31) / 32;
    localparam int PIDX_W    = $clog2(PIN_NUM);
    localparam int BIDX_W    = $clog2(BLK_IN_NUM);
    localparam int FIDX_W    = (FW > 1) ? $clog2(FW) : 1;
    localparam int LAST_BITS = PIN_NUM - 32 * (FW - 1);
    localparam logic [31:0] LAST_MASK =
        (LAST_BITS == 32) ? 32'hFFFF_FFFF : ((32'd1 << LAST_BITS) - 32'd1);
    localparam int OEXT = 1 << OSEL_W;
    localparam int IEXT = 1 << ISEL_W;

    logic [OSEL_W-1:0] out_sel [PIN_NUM];
    logic [ISEL_W-1:0] in_sel  [BLK_IN_NUM];
    logic [31:0]       filt_en [FW];
    logic              lock;

    reg_addr_s   addr;
    logic [31:0] idx32;
    logic        hit;
    logic        range_ok;
    logic [31:0] rd_val;
    logic        lock_noop;
    logic        wr_ok;
    logic        req_err;

    assign addr  = reg_addr_s'(reg_addr_i);
    assign idx32 = 32'(addr.idx);

    // Address decode, read mux and select-range check for the current request.
    always_comb begin
        hit      = 1'b0;
        range_ok = 1'b1;
        rd_val   = '0;
        if (addr.byte_off == 2'b00) begin
            case (addr.region)
                REGION_OUT_SEL: if (idx32 < 32'(PIN_NUM)) begin
                    hit      = 1'b1;
                    rd_val   = 32'(out_sel[addr.idx[PIDX_W-1:0]]);
                    range_ok = (reg_wdata_i <= 32'(BLK_OUT_NUM));
                end
                REGION_IN_SEL: if (idx32 < 32'(BLK_IN_NUM)) begin
                    hit      = 1'b1;
                    rd_val   = 32'(in_sel[addr.idx[BIDX_W-1:0]]);
                    range_ok = (reg_wdata_i <= 32'(PIN_NUM));
                end
                REGION_FILT_EN: if (idx32 < 32'(FW)) begin
                    hit    = 1'b1;
                    rd_val = filt_en[addr.idx[FIDX_W-1:0]];
                end
                default: if (addr.idx == '0) begin
                    hit                   = 1'b1;
                    rd_val[CTRL_LOCK_BIT] = lock;
                end
            endcase
        end
    end

    // Re-asserting lock while locked is harmless and reports no error.
    assign lock_noop = lock && (addr.region == REGION_CTRL) && reg_wdata_i[CTRL_LOCK_BIT];
    assign wr_ok     = reg_req_i && reg_we_i && hit && range_ok && !lock;
    assign req_err   = reg_req_i && (!hit || (reg_we_i && !wr_ok && !lock_noop));

    // One-cycle response strobe with read data and error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_rvalid_o <= 1'b0;
            reg_err_o    <= 1'b0;
            reg_rdata_o  <= '0;
        end else begin
            reg_rvalid_o <= reg_req_i;
            reg_err_o    <= req_err;
            reg_rdata_o  <= (reg_req_i && !reg_we_i && hit) ? rd_val : '0;
        end
    end

    // Configuration registers; lock can only be cleared by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_sel <= '{default: '0};
            in_sel  <= '{default: '0};
            filt_en <= '{default: '0};
            lock    <= 1'b0;
        end else if (wr_ok) begin
            case (addr.region)
                REGION_OUT_SEL: out_sel[addr.idx[PIDX_W-1:0]] <= reg_wdata_i[OSEL_W-1:0];
                REGION_IN_SEL:  in_sel[addr.idx[BIDX_W-1:0]]  <= reg_wdata_i[ISEL_W-1:0];
                REGION_FILT_EN: filt_en[addr.idx[FIDX_W-1:0]] <= reg_wdata_i &
                    ((idx32 == 32'(FW - 1)) ? LAST_MASK : 32'hFFFF_FFFF);
                default:        lock <= reg_wdata_i[CTRL_LOCK_BIT];
            endcase
        end
    end

    // Bit 0 of each extended vector is the "off" source so a select indexes directly.
    logic [OEXT-1:0]    out_ext;
    logic [OEXT-1:0]    oe_ext;
    logic [IEXT-1:0]    in_ext;
    logic [PIN_NUM-1:0] filt_q;

    assign out_ext = OEXT'({blk_out_i, 1'b0});
    assign oe_ext  = OEXT'({blk_oe_i, 1'b0});
    assign in_ext  = IEXT'({filt_q, 1'b0});

    for (genvar p = 0; p < PIN_NUM; p++) begin : g_pin
        assign pin_out_o[p] = out_ext[out_sel[p]];
        assign pin_oe_o[p]  = oe_ext[out_sel[p]];

        sonata_pin_filter #(
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_filter (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .en_i (filt_en[p / 32][p % 32]),
            .d_i  (pin_in_i[p]),
            .q_o  (filt_q[p])
        );
    end

    for (genvar b = 0; b < BLK_IN_NUM; b++) begin : g_blk_in
        assign blk_in_o[b] = (in_sel[b] != '0) ? in_ext[in_sel[b]] : BLK_IN_DEFAULT[b];
    end

endmodule

// File: tb/tb_sonata_pinmux_prog.sv
// Directed self-checking bench for the programmable pin multiplexer.
module tb_sonata_pinmux_prog;

    localparam int PIN_NUM     = 70;
    localparam int BLK_OUT_NUM = 48;
    localparam int BLK_IN_NUM  = 24;

    logic                   clk_i;
    logic                   rst_i;
    logic                   reg_req_i;
    logic                   reg_we_i;
    logic [11:0]            reg_addr_i;
    logic [31:0]            reg_wdata_i;
    logic [31:0]            reg_rdata_o;
    logic                   reg_rvalid_o;
    logic                   reg_err_o;
    logic [BLK_OUT_NUM-1:0] blk_out_i;
    logic [BLK_OUT_NUM-1:0] blk_oe_i;
    logic [BLK_IN_NUM-1:0]  blk_in_o;
    logic [PIN_NUM-1:0]     pin_in_i;
    logic [PIN_NUM-1:0]     pin_out_o;
    logic [PIN_NUM-1:0]     pin_oe_o;

    int checks = 0;
    int errors = 0;

    sonata_pinmux_prog dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .reg_req_i   (reg_req_i),
        .reg_we_i    (reg_we_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_rdata_o (reg_rdata_o),
        .reg_rvalid_o(reg_rvalid_o),
        .reg_err_o   (reg_err_o),
        .blk_out_i   (blk_out_i),
        .blk_oe_i    (blk_oe_i),
        .blk_in_o    (blk_in_o),
        .pin_in_i    (pin_in_i),
        .pin_out_o   (pin_out_o),
        .pin_oe_o    (pin_oe_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reg_op(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
        @(posedge clk_i);
        #1;
        reg_req_i   = 1'b1;
        reg_we_i    = we;
        reg_addr_i  = addr;
        reg_wdata_i = wdata;
        @(posedge clk_i);
        #1;
        reg_req_i = 1'b0;
        reg_we_i  = 1'b0;
        chk("rvalid", 80'(reg_rvalid_o), 80'd1);
        rdata = reg_rdata_o;
        err   = reg_err_o;
    endtask

    task automatic wr(input string tag, input logic [11:0] addr, input logic [31:0] wdata,
                      input logic exp_err);
        logic [31:0] rd;
        logic        er;
        reg_op(1'b1, addr, wdata, rd, er);
        chk(tag, 80'(er), 80'(exp_err));
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp_data,
                      input logic exp_err);
        logic [31:0] d;
        logic        er;
        reg_op(1'b0, addr, 32'd0, d, er);
        chk({tag, "_data"}, 80'(d), 80'(exp_data));
        chk({tag, "_err"}, 80'(er), 80'(exp_err));
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_i       = 1'b1;
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
        blk_out_i   = '0;
        blk_oe_i    = '0;
        pin_in_i    = '1;
        #12;
        chk("rst_oe", 80'(pin_oe_o), 80'd0);
        chk("rst_out", 80'(pin_out_o), 80'd0);
        chk("rst_blk_in", 80'(blk_in_o), 80'hFF_FFFF);
        chk("rst_rvalid", 80'(reg_rvalid_o), 80'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        rd("rd_out0", 12'h000, 32'd0, 1'b0);
        rd("rd_in0", 12'h400, 32'd0, 1'b0);
        rd("rd_ctrl", 12'hC00, 32'd0, 1'b0);

        // Output routing, including a shared source
        blk_out_i[2] = 1'b1;
        blk_oe_i[2]  = 1'b1;
        wr("wr_out5", 12'h014, 32'd3, 1'b0);
        chk("pin5_out", 80'(pin_out_o[5]), 80'd1);
        chk("pin5_oe", 80'(pin_oe_o[5]), 80'd1);
        chk("pin4_out", 80'(pin_out_o[4]), 80'd0);
        wr("wr_out6", 12'h018, 32'd3, 1'b0);
        chk("pin6_oe", 80'(pin_oe_o[6]), 80'd1);
        blk_out_i[2] = 1'b0;
        #1;
        chk("pin5_out_lo", 80'(pin_out_o[5]), 80'd0);
        chk("pin5_oe_hold", 80'(pin_oe_o[5]), 80'd1);
        wr("wr_out5_off", 12'h014, 32'd0, 1'b0);
        chk("pin5_oe_off", 80'(pin_oe_o[5]), 80'd0);

        // Unfiltered input path: 3 cycles pad to block
        wr("wr_in0", 12'h400, 32'd20, 1'b0);
        chk("blk_in0_hi", 80'(blk_in_o[0]), 80'd1);
        pin_in_i[19] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("unf_t%0d", i), 80'(blk_in_o[0]), (i < 3) ? 80'd1 : 80'd0);
        end
        pin_in_i[19] = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        chk("unf_back_hi", 80'(blk_in_o[0]), 80'd1);

        // Filtered: short pulse suppressed, 4-cycle low passes at t+6
        wr("wr_filt0", 12'h800, 32'h0008_0000, 1'b0);
        rd("rd_filt0", 12'h800, 32'h0008_0000, 1'b0);
        pin_in_i[19] = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 pin_in_i[19] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("pulse_c%0d", i), 80'(blk_in_o[0]), 80'd1);
        end
        pin_in_i[19] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("filt_t%0d", i), 80'(blk_in_o[0]), (i < 6) ? 80'd1 : 80'd0);
        end

        // Range and map errors
        wr("wr_out0_big", 12'h000, 32'd49, 1'b1);
        rd("rd_out0_keep", 12'h000, 32'd0, 1'b0);
        wr("wr_out0_max", 12'h000, 32'd48, 1'b0);
        rd("rd_out0_max", 12'h000, 32'd48, 1'b0);
        wr("wr_in1_big", 12'h404, 32'd71, 1'b1);
        rd("rd_in1_keep", 12'h404, 32'd0, 1'b0);
        rd("rd_unmapped", 12'hFFC, 32'd0, 1'b1);
        rd("rd_in24", 12'h460, 32'd0, 1'b1);
        wr("wr_filt3", 12'h80C, 32'd1, 1'b1);
        wr("wr_filt2", 12'h808, 32'hFFFF_FFFF, 1'b0);
        rd("rd_filt2", 12'h808, 32'h0000_003F, 1'b0);

        // Lock behaviour
        wr("wr_lock", 12'hC00, 32'd1, 1'b0);
        rd("rd_lock", 12'hC00, 32'd1, 1'b0);
        wr("wr_out1_lk", 12'h004, 32'd2, 1'b1);
        rd("rd_out1_lk", 12'h004, 32'd0, 1'b0);
        wr("wr_lock_again", 12'hC00, 32'd1, 1'b0);
        wr("wr_unlock", 12'hC00, 32'd0, 1'b1);
        rd("rd_lock_kept", 12'hC00, 32'd1, 1'b0);

        // Asynchronous reset mid-operation
        blk_out_i[47] = 1'b1;
        blk_oe_i[47]  = 1'b1;
        #1;
        chk("pin0_oe_pre", 80'(pin_oe_o[0]), 80'd1);
        chk("blk_in0_pre", 80'(blk_in_o[0]), 80'd0);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_oe", 80'(pin_oe_o), 80'd0);
        chk("arst_out", 80'(pin_out_o), 80'd0);
        chk("arst_blk_in", 80'(blk_in_o), 80'hFF_FFFF);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        rd("rd_ctrl_rst", 12'hC00, 32'd0, 1'b0);
        rd("rd_out0_rst", 12'h000, 32'd0, 1'b0);
        wr("wr_out1_unlk", 12'h004, 32'd2, 1'b0);
        rd("rd_out1_unlk", 12'h004, 32'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
